// File: rtl/eth_rx_pkg.sv
// Shared types and sizing for the Ethernet receive header FIFO.
// ETH_RX_FIFO_OVF_EN adds the overflow status ports on eth_rx_fifo.
package eth_rx_pkg;

  typedef logic [7:0] eth_byte_t;

  localparam int ETH_RX_FIFO_DEPTH = 16;
  localparam int OVF_CNT_W         = 8;

endpackage

// File: rtl/eth_rx_fifo_mem.sv
// DEPTH x 8 register file for the receive FIFO.
// One synchronous write port, one asynchronous read port, no reset.
import eth_rx_pkg::*;

module eth_rx_fifo_mem #(
  parameter int DEPTH = ETH_RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  eth_byte_t     wdata,
  input  logic [AW-1:0] raddr,
  output eth_byte_t     rdata
);

  eth_byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/eth_rx_fifo.sv
// FWFT byte FIFO capturing decoded SA/LEN header bytes.
// Define ETH_RX_FIFO_OVF_EN for the sticky overflow flag and drop counter.
import eth_rx_pkg::*;

module eth_rx_fifo #(
  parameter int DEPTH = ETH_RX_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  eth_byte_t              E_Data,
  input  logic                   w_enable,
  output logic                   FULL,
  input  logic                   r_enable,
  output eth_byte_t              R_Data,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] count
`ifdef ETH_RX_FIFO_OVF_EN
  ,
  input  logic                   ovf_clr,
  output logic                   ovf,
  output logic [OVF_CNT_W-1:0]   ovf_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_ok, rd_ok;
  eth_byte_t        rdata;

  // Flags are registered, so acceptance only sees last edge's state.
  assign wr_ok = w_enable && !full_q;
  assign rd_ok = r_enable && !empty_q;

  always_comb begin
    wptr_d  = wr_ok ? wptr_q + ONE : wptr_q;
    rptr_d  = rd_ok ? rptr_q + ONE : rptr_q;
    cnt_d   = wptr_d - rptr_d;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[ADDR_W] != rptr_d[ADDR_W]) &&
              (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  eth_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata (E_Data),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (rdata)
  );

  assign R_Data = empty_q ? 8'h00 : rdata;
  assign FULL   = full_q;
  assign EMPTY  = empty_q;
  assign count  = cnt_q;

`ifdef ETH_RX_FIFO_OVF_EN
  logic                 ovf_q, ovf_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                 drop;

  assign drop = w_enable && full_q;

  // A drop in the clearing cycle survives the clear as the first event.
  always_comb begin
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_d     = drop;
      ovf_cnt_d = drop ? OVF_CNT_W'(1) : '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (ovf_cnt_q != '1) begin
        ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf       = ovf_q;
  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_eth_rx_fifo.sv
// Scoreboard bench for eth_rx_fifo.
// Overflow checks compile in when ETH_RX_FIFO_OVF_EN is defined.
module tb_eth_rx_fifo;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] E_Data = 8'h00;
  logic       w_enable = 1'b0;
  logic       r_enable = 1'b0;
  logic       FULL;
  logic       EMPTY;
  logic [7:0] R_Data;
  logic [4:0] count;
`ifdef ETH_RX_FIFO_OVF_EN
  logic       ovf_clr = 1'b0;
  logic       ovf;
  logic [7:0] ovf_count;
`endif

  int n_run = 0;
  int n_fail = 0;
  logic [7:0] sb [$];

  eth_rx_fifo dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .E_Data   (E_Data),
    .w_enable (w_enable),
    .FULL     (FULL),
    .r_enable (r_enable),
    .R_Data   (R_Data),
    .EMPTY    (EMPTY),
    .count    (count)
`ifdef ETH_RX_FIFO_OVF_EN
    ,
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
    .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic w, input logic [7:0] d,
                    input logic r);
    logic       wa, ra;
    logic [7:0] e;
    @(negedge clk);
    wa = w && (sb.size() < 16);
    ra = r && (sb.size() > 0);
    if (ra) begin
      e = sb.pop_front();
      chk("rdata", 32'(R_Data), 32'(e));
    end
    if (wa) sb.push_back(d);
    w_enable = w;
    E_Data   = d;
    r_enable = r;
    @(posedge clk);
    #1;
    w_enable = 1'b0;
    r_enable = 1'b0;
    chk("count", 32'(count), 32'(sb.size()));
    chk("full", 32'(FULL), 32'(sb.size() == 16));
    chk("empty", 32'(EMPTY), 32'(sb.size() == 0));
    if (sb.size() == 0) chk("rdata_idle", 32'(R_Data), 32'h0);
  endtask

  task automatic do_reset();
    #2 n_rst = 1'b0;
    #1;
    chk("rst_empty", 32'(EMPTY), 32'h1);
    chk("rst_full", 32'(FULL), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_rdata", 32'(R_Data), 32'h0);
    sb.delete();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    // power-on reset
    repeat (2) @(negedge clk);
    chk("por_empty", 32'(EMPTY), 32'h1);
    chk("por_count", 32'(count), 32'h0);
    n_rst = 1'b1;

    // header capture: 6 SA + 2 LEN bytes
    for (int i = 0; i < 8; i++) op(1'b1, 8'hFB, 1'b0);
    chk("hdr_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) op(1'b0, 8'h00, 1'b1);
    chk("hdr_empty", 32'(EMPTY), 32'h1);

    // reset mid-run with data held
    for (int i = 0; i < 5; i++) op(1'b1, 8'(8'h30 + i), 1'b0);
    do_reset();

    // fill, drop while full, drain in order
    for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(FULL), 32'h1);
    op(1'b1, 8'hAA, 1'b0);
    chk("drop_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1);

    // wrap across index 15 -> 0
    do_reset();
    for (int i = 0; i < 10; i++) op(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) op(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) op(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("wrap_count", 32'(count), 32'd12);
    for (int i = 0; i < 12; i++) op(1'b0, 8'h00, 1'b1);

    // simultaneous ops: full then empty
    for (int i = 0; i < 16; i++) op(1'b1, 8'(8'h80 + i), 1'b0);
    op(1'b1, 8'h55, 1'b1);
    chk("full_wr_rd", 32'(count), 32'd15);
    for (int i = 0; i < 7; i++) op(1'b1, 8'(8'h60 + i), 1'b1);
    for (int i = 0; i < 15; i++) op(1'b0, 8'h00, 1'b1);
    op(1'b1, 8'h77, 1'b1);
    chk("empty_wr_rd_cnt", 32'(count), 32'd1);
    chk("empty_wr_rd_dat", 32'(R_Data), 32'h77);
    op(1'b0, 8'h00, 1'b1);

    // randomised mix against the scoreboard
    for (int i = 0; i < 200; i++)
      op(1'($urandom_range(0, 1)), 8'($urandom),
         1'($urandom_range(0, 1)));

`ifdef ETH_RX_FIFO_OVF_EN
    do_reset();
    chk("ovf_rst", 32'(ovf), 32'h0);
    chk("ovf_cnt_rst", 32'(ovf_count), 32'h0);
    for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0);
    chk("ovf_none", 32'(ovf), 32'h0);
    for (int i = 0; i < 3; i++) op(1'b1, 8'hEE, 1'b0);
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_cnt3", 32'(ovf_count), 32'd3);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'h0);
    chk("ovf_cnt_clr", 32'(ovf_count), 32'h0);
    @(negedge clk);
    ovf_clr  = 1'b1;
    w_enable = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    w_enable = 1'b0;
    chk("ovf_clr_drop", 32'(ovf), 32'h1);
    chk("ovf_cnt_clr_drop", 32'(ovf_count), 32'd1);
    for (int i = 0; i < 300; i++) op(1'b1, 8'hEE, 1'b0);
    chk("ovf_sat", 32'(ovf_count), 32'hFF);
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
